// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: load-use stalls,
// taken-branch flushes, external freezes and debug counters.
module pipe_stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_mem_read,
  input  logic [4:0]  id_ex_rt,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        ex_branch_taken,
  input  logic        ext_stall,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        pc_sel_branch,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    BR_FLUSH = 2'b10,
    BAD      = 2'b11
  } st_t;

  st_t  st_q;
  st_t  st_nx;
  logic pending;
  logic pending_nx;
  logic service;
  logic lu_hazard;
  logic branch;

  assign lu_hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                     ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
  assign branch    = ex_branch_taken || pending;
  assign state     = st_q;

  // Output and next-state decode from registered state, pending flag and inputs
  always_comb begin
    st_nx         = st_q;
    pending_nx    = pending;
    service       = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    pc_sel_branch = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      st_nx        = RUN;
      pending_nx   = 1'b0;
    end else if (ext_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if (st_q == BAD)
        st_nx = RUN;
      // A branch seen in BR_FLUSH is wrong-path and never remembered
      if (ex_branch_taken && (st_q != BR_FLUSH))
        pending_nx = 1'b1;
    end else begin
      case (st_q)
        RUN, LU_STALL: begin
          if (branch) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pc_write     = 1'b0;
            service      = 1'b1;
            pending_nx   = 1'b0;
            st_nx        = BR_FLUSH;
          end else if ((st_q == RUN) && lu_hazard) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            st_nx        = LU_STALL;
          end else begin
            st_nx = RUN;
          end
        end
        BR_FLUSH: begin
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          pending_nx    = 1'b0;
          st_nx         = RUN;
        end
        default: begin
          // Illegal encoding: recover to RUN, keep any live branch pending
          st_nx      = RUN;
          pending_nx = pending || ex_branch_taken;
        end
      endcase
    end
  end

  // State, pending flag and saturating counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q         <= RUN;
      pending      <= 1'b0;
      stall_cycles <= 16'd0;
      flush_count  <= 16'd0;
    end else begin
      st_q    <= st_nx;
      pending <= pending_nx;
      if (!pc_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (service && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end

endmodule
